// File: rtl/line_fill_requester.sv
// Line-fill initiator: converts one cache miss into a single 64B memory line read
// and returns the line plus critical word, with a timeout against a silent memory.
module line_fill_requester #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [511:0]      mem_data,
  input  logic              mem_ready,
  output logic              fill_valid,
  input  logic              fill_ready,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [511:0]      fill_line,
  output logic [WORD_W-1:0] fill_word,
  output logic              fill_error,
  output logic              busy
);

  localparam int unsigned OFF_LSB = $clog2(WORD_W / 8);
  localparam int unsigned IDX_W   = 6 - OFF_LSB;
  localparam logic [7:0]  LAST_TICK = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t           state;
  logic [7:0]       timer;
  logic [IDX_W-1:0] word_idx;
  logic [WORD_W-1:0] sel_word_c;

  assign sel_word_c = mem_data[WORD_W*word_idx +: WORD_W];

  // Gated by rst_n so nothing advertises readiness while reset is held.
  assign miss_ready = rst_n && (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      word_idx   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_line  <= '0;
      fill_word  <= '0;
      fill_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_valid) begin
            word_idx <= miss_addr[5:OFF_LSB];
            mem_addr <= {miss_addr[ADDR_W-1:6], 6'b0};
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          mem_req <= 1'b0;
          timer   <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // Data arriving on the final timeout cycle still wins.
          if (mem_ready) begin
            fill_line  <= mem_data;
            fill_word  <= sel_word_c;
            fill_error <= 1'b0;
            fill_addr  <= mem_addr;
            fill_valid <= 1'b1;
            state      <= RESP;
          end else if (timer == LAST_TICK) begin
            timer      <= timer + 8'd1;
            fill_line  <= '0;
            fill_word  <= '0;
            fill_error <= 1'b1;
            fill_addr  <= mem_addr;
            fill_valid <= 1'b1;
            state      <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          if (fill_ready) begin
            fill_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_requester.sv
// Directed bench: DUT a (TIMEOUT=255) with a 100-cycle memory, DUT b (TIMEOUT=8) for timeouts.
module tb_line_fill_requester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_miss_valid, a_miss_ready, a_mem_req, a_mem_ready, a_fill_valid, a_fill_ready;
  logic         a_fill_error, a_busy;
  logic [31:0]  a_miss_addr, a_mem_addr, a_fill_addr, a_fill_word;
  logic [511:0] a_mem_data, a_fill_line;

  logic         b_miss_valid, b_miss_ready, b_mem_req, b_mem_ready, b_fill_valid, b_fill_ready;
  logic         b_fill_error, b_busy;
  logic [31:0]  b_miss_addr, b_mem_addr, b_fill_addr, b_fill_word;
  logic [511:0] b_mem_data, b_fill_line;

  line_fill_requester #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(255)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .miss_valid(a_miss_valid), .miss_addr(a_miss_addr),
    .miss_ready(a_miss_ready), .mem_req(a_mem_req), .mem_addr(a_mem_addr),
    .mem_data(a_mem_data), .mem_ready(a_mem_ready), .fill_valid(a_fill_valid),
    .fill_ready(a_fill_ready), .fill_addr(a_fill_addr), .fill_line(a_fill_line),
    .fill_word(a_fill_word), .fill_error(a_fill_error), .busy(a_busy)
  );

  line_fill_requester #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .miss_valid(b_miss_valid), .miss_addr(b_miss_addr),
    .miss_ready(b_miss_ready), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
    .mem_data(b_mem_data), .mem_ready(b_mem_ready), .fill_valid(b_fill_valid),
    .fill_ready(b_fill_ready), .fill_addr(b_fill_addr), .fill_line(b_fill_line),
    .fill_word(b_fill_word), .fill_error(b_fill_error), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [511:0] line1, line2;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int req_cnt;
    int vld_cnt;
    logic stable;

    for (int i = 0; i < 16; i++) line1[32*i +: 32] = 32'hC0DE_0000 | 32'(i);
    line2 = ~line1;
    a_miss_valid = 0; a_miss_addr = '0; a_mem_data = '0; a_mem_ready = 0; a_fill_ready = 0;
    b_miss_valid = 0; b_miss_addr = '0; b_mem_data = '0; b_mem_ready = 0; b_fill_ready = 0;

    // 1: reset values, then release
    #7;
    chk("rst_miss_ready", 512'(a_miss_ready), 512'(0));
    chk("rst_mem_req", 512'(a_mem_req), 512'(0));
    chk("rst_mem_addr", 512'(a_mem_addr), 512'(0));
    chk("rst_fill_valid", 512'(a_fill_valid), 512'(0));
    chk("rst_fill_line", a_fill_line, 512'(0));
    chk("rst_fill_word", 512'(a_fill_word), 512'(0));
    chk("rst_fill_error", 512'(a_fill_error), 512'(0));
    chk("rst_busy", 512'(a_busy), 512'(0));
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rel_miss_ready", 512'(a_miss_ready), 512'(1));
    chk("rel_busy", 512'(a_busy), 512'(0));

    // 2: miss 0x1234 against 100-cycle memory
    tick();
    a_miss_valid = 1; a_miss_addr = 32'h0000_1234;
    tick();
    a_miss_valid = 0;
    chk("t2_mem_req", 512'(a_mem_req), 512'(1));
    chk("t2_mem_addr", 512'(a_mem_addr), 512'(32'h0000_1200));
    chk("t2_busy", 512'(a_busy), 512'(1));
    chk("t2_miss_ready", 512'(a_miss_ready), 512'(0));
    req_cnt = 0; vld_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (a_mem_req) req_cnt++;
      if (a_fill_valid) vld_cnt++;
      if (a_mem_addr != 32'h0000_1200) req_cnt += 100;
    end
    chk("t2_no_extra_req", 512'(req_cnt), 512'(0));
    chk("t2_no_early_fill", 512'(vld_cnt), 512'(0));
    a_mem_ready = 1; a_mem_data = line1;
    tick();
    a_mem_ready = 0; a_mem_data = {16{32'hDEAD_BEEF}};
    chk("t2_fill_valid", 512'(a_fill_valid), 512'(1));
    chk("t2_fill_line", a_fill_line, line1);
    chk("t2_fill_word", 512'(a_fill_word), 512'(32'hC0DE_000D));
    chk("t2_fill_error", 512'(a_fill_error), 512'(0));
    chk("t2_fill_addr", 512'(a_fill_addr), 512'(32'h0000_1200));

    // 3: stall 20 cycles, handshake, back-to-back miss
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_fill_valid !== 1'b1 || a_fill_line !== line1 || a_fill_word !== 32'hC0DE_000D ||
          a_fill_error !== 1'b0 || a_fill_addr !== 32'h0000_1200) stable = 1'b0;
    end
    chk("t3_stable", 512'(stable), 512'(1));
    a_fill_ready = 1;
    tick();
    a_fill_ready = 0;
    chk("t3_fill_valid_low", 512'(a_fill_valid), 512'(0));
    chk("t3_idle", 512'(a_miss_ready), 512'(1));
    a_miss_valid = 1; a_miss_addr = 32'h0000_4008;
    tick();
    a_miss_valid = 0;
    chk("t3_b2b_req", 512'(a_mem_req), 512'(1));
    chk("t3_b2b_addr", 512'(a_mem_addr), 512'(32'h0000_4000));
    tick();
    chk("t3_req_single", 512'(a_mem_req), 512'(0));
    a_mem_ready = 1; a_mem_data = line2;
    tick();
    a_mem_ready = 0;
    chk("t3_fill_word", 512'(a_fill_word), 512'(32'h3F21_FFFD));
    chk("t3_fill_line", a_fill_line, line2);
    a_fill_ready = 1;
    tick();
    a_fill_ready = 0;

    // 4: dead memory on DUT b, timeout after 8 WAIT cycles
    b_miss_valid = 1; b_miss_addr = 32'h8000_0040;
    tick();
    b_miss_valid = 0;
    chk("t4_req", 512'(b_mem_req), 512'(1));
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t4_not_yet", 512'(b_fill_valid), 512'(0));
    tick();
    chk("t4_fill_valid", 512'(b_fill_valid), 512'(1));
    chk("t4_fill_error", 512'(b_fill_error), 512'(1));
    chk("t4_fill_line", b_fill_line, 512'(0));
    chk("t4_fill_word", 512'(b_fill_word), 512'(0));
    chk("t4_fill_addr", 512'(b_fill_addr), 512'(32'h8000_0040));
    b_fill_ready = 1;
    tick();
    b_fill_ready = 0;
    b_mem_ready = 1; b_mem_data = {512{1'b1}};
    tick();
    b_mem_ready = 0;
    tick();
    chk("t4_stray_valid", 512'(b_fill_valid), 512'(0));
    chk("t4_stray_line", b_fill_line, 512'(0));
    chk("t4_stray_error", 512'(b_fill_error), 512'(1));
    chk("t4_stray_busy", 512'(b_busy), 512'(0));

    // 5: mem_ready on the last timeout cycle wins
    b_miss_valid = 1; b_miss_addr = 32'h0000_0A0C;
    tick();
    b_miss_valid = 0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t5_not_yet", 512'(b_fill_valid), 512'(0));
    b_mem_ready = 1; b_mem_data = line1;
    tick();
    b_mem_ready = 0;
    chk("t5_fill_valid", 512'(b_fill_valid), 512'(1));
    chk("t5_fill_error", 512'(b_fill_error), 512'(0));
    chk("t5_fill_line", b_fill_line, line1);
    chk("t5_fill_word", 512'(b_fill_word), 512'(32'hC0DE_0003));
    b_fill_ready = 1;
    tick();
    b_fill_ready = 0;

    // 6: async reset mid-WAIT, then a fresh miss
    a_miss_valid = 1; a_miss_addr = 32'h0000_2044;
    tick();
    a_miss_valid = 0;
    tick(); tick(); tick();
    chk("t6_busy_before", 512'(a_busy), 512'(1));
    #2 rst_n = 0;
    #1;
    chk("t6_rst_mem_addr", 512'(a_mem_addr), 512'(0));
    chk("t6_rst_busy", 512'(a_busy), 512'(0));
    chk("t6_rst_fill_valid", 512'(a_fill_valid), 512'(0));
    chk("t6_rst_fill_line", a_fill_line, 512'(0));
    @(negedge clk);
    rst_n = 1;
    tick();
    a_miss_valid = 1; a_miss_addr = 32'h0000_3038;
    tick();
    a_miss_valid = 0;
    chk("t6_req", 512'(a_mem_req), 512'(1));
    chk("t6_addr", 512'(a_mem_addr), 512'(32'h0000_3000));
    for (int i = 0; i < 5; i++) tick();
    a_mem_ready = 1; a_mem_data = line1;
    tick();
    a_mem_ready = 0;
    chk("t6_fill_valid", 512'(a_fill_valid), 512'(1));
    chk("t6_fill_word", 512'(a_fill_word), 512'(32'hC0DE_000E));
    chk("t6_fill_error", 512'(a_fill_error), 512'(0));
    a_fill_ready = 1;
    tick();
    a_fill_ready = 0;
    chk("t6_idle", 512'(a_miss_ready), 512'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
